stream_demux_1_4: RTL

- Inverse of the index-based 4:1 mux: routes one valid/ready input stream to one of N_OUT output streams chosen by a per-transfer index.
- Each output has a one-entry registered slot, so every output stalls independently and output-side timing is cut.
- Sits between a single producer and N_OUT consumers, for example to fan work out to parallel units.

---
 rtl/stream_demux_slot.sv | 41 ++++
 rtl/stream_demux_1_4.sv | 58 +++++
 2 files changed

// File: rtl/stream_demux_slot.sv
// One-entry registered output slot for the 1:4 stream demux.
// Holds a single payload per output so each consumer stalls independently
// and the output side is fully registered.
module stream_demux_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  // Slot is free, or is being drained this cycle, so it can take new data.
  always_comb begin
    can_load = !out_valid || out_ready;
  end

  // Valid flag: load has priority over drain so a full slot with a ready
  // consumer sustains one transfer per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Payload register; not reset since it is don't-care while invalid.
  always_ff @(posedge clk) begin
    if (load) begin
      out_data <= load_data;
    end
  end

endmodule

// File: rtl/stream_demux_1_4.sv
// Routes one valid/ready input stream to one of N_OUT registered output
// slots selected per transfer by in_sel. Out-of-range indices are accepted
// and dropped.
module stream_demux_1_4 #(
  parameter int N_OUT = 4,
  parameter int WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  input  logic [$clog2(N_OUT)-1:0]       in_sel,
  output logic [N_OUT-1:0]               out_valid,
  input  logic [N_OUT-1:0]               out_ready,
  output logic [N_OUT*WIDTH-1:0]         out_data
);

  localparam int SEL_W = $clog2(N_OUT);

  logic [N_OUT-1:0] can_load;
  logic [N_OUT-1:0] load;

  // Acceptance: indexed slot must be able to load; an index that matches no
  // slot is always accepted so the producer never deadlocks on it.
  always_comb begin
    in_ready = !rst;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (in_sel == SEL_W'(i)) begin
        in_ready = !rst && can_load[i];
      end
    end
  end

  // One-hot load strobe for the addressed slot on an input transfer.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      load[i] = in_valid && in_ready && (in_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    stream_demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[g]),
      .load_data(in_data),
      .out_ready(out_ready[g]),
      .out_valid(out_valid[g]),
      .out_data (out_data[g*WIDTH +: WIDTH]),
      .can_load (can_load[g])
    );
  end

endmodule
